// File: rtl/soc_bus_pkg.sv
// Shared definitions for the SoC shared-memory bus: arbiter state encoding
// and default address/data widths (also used by the memory decoder).
package soc_bus_pkg;

  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } bus_state_e;

endpackage

// File: rtl/soc_bus_arbiter.sv
// Two-master round-robin arbiter for the shared ROM/RAM port.
// M0 = loader/debug, M1 = core load/store. The owner is muxed onto the slave
// port; a tenure is cut short after MAX_BEATS acks only if the other master waits.
module soc_bus_arbiter
  import soc_bus_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int MAX_BEATS = 16
) (
  input  logic          clk_100MHz,
  input  logic          arst_n,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  input  logic          m0_we,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_ack,
  input  logic          m1_req,
  input  logic [AW-1:0] m1_addr,
  input  logic          m1_we,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_ack,
  output logic [AW-1:0] slv_addr,
  output logic          slv_we,
  output logic [DW-1:0] slv_wdata,
  output logic          slv_valid,
  input  logic          slv_ack,
  input  logic [DW-1:0] slv_rdata,
  output logic [DW-1:0] rdata,
  output logic          hold_o
);

  localparam int            CW      = $clog2(MAX_BEATS + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BEATS);

  bus_state_e    state_reg;
  logic          last_reg;      // 1 = M1 owned most recently, so M0 wins a tie
  logic [CW-1:0] beat_cnt_reg;

  logic          own_req;
  logic          oth_req;
  logic          beat_done;
  logic [CW-1:0] cnt_sat;
  bus_state_e    other_state;

  // Request of the current owner and of the competing master
  always_comb begin
    own_req     = 1'b0;
    oth_req     = 1'b0;
    other_state = IDLE;
    case (state_reg)
      OWN0: begin
        own_req     = m0_req;
        oth_req     = m1_req;
        other_state = OWN1;
      end
      OWN1: begin
        own_req     = m1_req;
        oth_req     = m0_req;
        other_state = OWN0;
      end
      default: ;
    endcase
  end

  // Beat count including the ack completing this cycle, saturating at MAX_BEATS,
  // so preemption happens on the same edge as the final permitted ack
  assign beat_done = slv_ack & slv_valid;
  assign cnt_sat   = (beat_done && beat_cnt_reg != MAX_CNT) ? beat_cnt_reg + 1'b1 : beat_cnt_reg;

  // Ownership FSM with round-robin tie-break and beat-limit preemption
  always_ff @(posedge clk_100MHz or negedge arst_n) begin
    if (!arst_n) begin
      state_reg    <= IDLE;
      last_reg     <= 1'b1;
      beat_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          beat_cnt_reg <= '0;
          if (m0_req && m1_req) state_reg <= last_reg ? OWN0 : OWN1;
          else if (m0_req)      state_reg <= OWN0;
          else if (m1_req)      state_reg <= OWN1;
        end
        OWN0, OWN1: begin
          if (!own_req) begin
            last_reg     <= (state_reg == OWN1);
            beat_cnt_reg <= '0;
            state_reg    <= oth_req ? other_state : IDLE;
          end else if (cnt_sat == MAX_CNT && oth_req) begin
            last_reg     <= (state_reg == OWN1);
            beat_cnt_reg <= '0;
            state_reg    <= other_state;
          end else begin
            beat_cnt_reg <= cnt_sat;
          end
        end
        default: begin
          state_reg    <= IDLE;
          beat_cnt_reg <= '0;
        end
      endcase
    end
  end

  // Slave-port mux and ack routing decoded from the owner
  always_comb begin
    slv_addr  = '0;
    slv_we    = 1'b0;
    slv_wdata = '0;
    slv_valid = 1'b0;
    case (state_reg)
      OWN0: begin
        slv_addr  = m0_addr;
        slv_we    = m0_we;
        slv_wdata = m0_wdata;
        slv_valid = m0_req;
      end
      OWN1: begin
        slv_addr  = m1_addr;
        slv_we    = m1_we;
        slv_wdata = m1_wdata;
        slv_valid = m1_req;
      end
      default: ;
    endcase
  end

  assign m0_gnt = (state_reg == OWN0);
  assign m1_gnt = (state_reg == OWN1);
  assign m0_ack = slv_ack & m0_gnt;
  assign m1_ack = slv_ack & m1_gnt;
  assign rdata  = slv_rdata;
  // Core is stalled while the loader owns the bus or while it waits for a grant
  assign hold_o = m0_gnt | (m1_req & ~m1_gnt);

endmodule

// File: tb/tb_soc_bus_arbiter.sv
// Directed scenarios followed by random traffic, compared every cycle against
// a behavioural owner/last/beats model of the arbitration rules.
module tb_soc_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MB = 4;

  logic          clk_100MHz = 1'b0;
  logic          arst_n;
  logic          m0_req, m0_we, m0_gnt, m0_ack;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m1_req, m1_we, m1_gnt, m1_ack;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic [AW-1:0] slv_addr;
  logic          slv_we, slv_valid, slv_ack, hold_o;
  logic [DW-1:0] slv_wdata, slv_rdata, rdata;

  int checks = 0;
  int errors = 0;

  // Reference model: owner -1 = nobody, 0 = M0, 1 = M1
  int own   = -1;
  int last  = 1;
  int beats = 0;

  always #5 clk_100MHz = ~clk_100MHz;

  soc_bus_arbiter #(.AW(AW), .DW(DW), .MAX_BEATS(MB)) dut (
    .clk_100MHz(clk_100MHz), .arst_n(arst_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_ack(m1_ack),
    .slv_addr(slv_addr), .slv_we(slv_we), .slv_wdata(slv_wdata),
    .slv_valid(slv_valid), .slv_ack(slv_ack), .slv_rdata(slv_rdata),
    .rdata(rdata), .hold_o(hold_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic r0, input logic r1, input logic a);
    m0_req    = r0;
    m1_req    = r1;
    slv_ack   = a;
    m0_addr   = $urandom;
    m0_wdata  = $urandom;
    m0_we     = 1'($urandom_range(0, 1));
    m1_addr   = $urandom;
    m1_wdata  = $urandom;
    m1_we     = 1'($urandom_range(0, 1));
    slv_rdata = $urandom;
  endtask

  // Compare every output with what the model's owner and current inputs imply
  task automatic check_all();
    logic          e_valid, e_we, e_hold;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    e_valid = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
    if (own == 0) begin
      e_valid = m0_req; e_we = m0_we; e_addr = m0_addr; e_wdata = m0_wdata;
    end else if (own == 1) begin
      e_valid = m1_req; e_we = m1_we; e_addr = m1_addr; e_wdata = m1_wdata;
    end
    e_hold = (own == 0) || (m1_req && own != 1);
    chk("m0_gnt", m0_gnt, own == 0);
    chk("m1_gnt", m1_gnt, own == 1);
    chk("m0_ack", m0_ack, slv_ack && own == 0);
    chk("m1_ack", m1_ack, slv_ack && own == 1);
    chk("slv_valid", slv_valid, e_valid);
    chk("slv_we", slv_we, e_we);
    chk("slv_addr", slv_addr, e_addr);
    chk("slv_wdata", slv_wdata, e_wdata);
    chk("rdata", rdata, slv_rdata);
    chk("hold_o", hold_o, e_hold);
  endtask

  // Arbitration rules applied to the inputs present at the coming edge
  task automatic model_step();
    logic rx, ry;
    int   y;
    if (own < 0) begin
      if (m0_req && m1_req) own = (last == 0) ? 1 : 0;
      else if (m0_req)      own = 0;
      else if (m1_req)      own = 1;
    end else begin
      y  = 1 - own;
      rx = (own == 0) ? m0_req : m1_req;
      ry = (own == 0) ? m1_req : m0_req;
      if (slv_ack && rx && beats < MB) beats++;
      if (!rx) begin
        last  = own;
        beats = 0;
        own   = ry ? y : -1;
      end else if (beats == MB && ry) begin
        last  = own;
        beats = 0;
        own   = y;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk_100MHz);
    check_all();
    model_step();
    @(posedge clk_100MHz);
    #1;
  endtask

  // Asynchronous reset asserted and released between clock edges
  task automatic reset_pulse();
    m0_req = 1'b0; m1_req = 1'b0; slv_ack = 1'b0;
    #1 arst_n = 1'b0;
    own = -1; last = 1; beats = 0;
    #1;
    chk("rst_m0_gnt", m0_gnt, 1'b0);
    chk("rst_m1_gnt", m1_gnt, 1'b0);
    chk("rst_valid", slv_valid, 1'b0);
    chk("rst_hold", hold_o, 1'b0);
    chk("rst_we", slv_we, 1'b0);
    chk("rst_addr", slv_addr, '0);
    #1 arst_n = 1'b1;
  endtask

  initial begin
    logic r0, r1;
    int   prev;
    arst_n = 1'b0;
    set_in(1'b0, 1'b0, 1'b0);
    #12;
    chk("init_m0_gnt", m0_gnt, 1'b0);
    chk("init_m1_gnt", m1_gnt, 1'b0);
    chk("init_valid", slv_valid, 1'b0);
    chk("init_hold", hold_o, 1'b0);
    @(posedge clk_100MHz);
    #3 arst_n = 1'b1;

    // Single master M1, three acks, then release
    set_in(1'b0, 1'b1, 1'b0);
    cycle();
    chk("t2_gnt", m1_gnt, 1'b1);
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 1'b1, 1'b1);
      m1_addr = 32'h100;
      #1 chk("t2_addr", slv_addr, 32'h100);
      chk("t2_ack", m1_ack, 1'b1);
      cycle();
    end
    set_in(1'b0, 1'b0, 1'b0);
    cycle();
    chk("t2_idle", m1_gnt, 1'b0);

    // Tie after reset goes to M0, then M1 follows with no idle gap
    reset_pulse();
    set_in(1'b1, 1'b1, 1'b0);
    cycle();
    chk("t3_gnt0", m0_gnt, 1'b1);
    chk("t3_hold", hold_o, 1'b1);
    set_in(1'b1, 1'b1, 1'b1);
    cycle();
    set_in(1'b0, 1'b1, 1'b0);
    cycle();
    chk("t3_gnt1", m1_gnt, 1'b1);

    // Preemption of M1 after MB acks while M0 waits
    reset_pulse();
    set_in(1'b0, 1'b1, 1'b0);
    cycle();
    for (int i = 0; i < MB; i++) begin
      chk("t4_m1_owns", m1_gnt, 1'b1);
      set_in(1'b1, 1'b1, 1'b1);
      cycle();
    end
    chk("t4_preempt", m0_gnt, 1'b1);
    set_in(1'b1, 1'b1, 1'b1);
    cycle();
    set_in(1'b0, 1'b1, 1'b0);
    cycle();
    chk("t4_regain", m1_gnt, 1'b1);

    // Round robin: each owner does one beat, drops, re-requests
    for (int k = 0; k < 4; k++) begin
      prev = m1_gnt ? 1 : 0;
      set_in(1'b1, 1'b1, 1'b1);
      cycle();
      set_in(1'(prev == 1), 1'(prev == 0), 1'b0);
      cycle();
      chk("t5_alt", m1_gnt, 1'(prev == 0));
    end

    // Reset in the middle of an M0 tenure
    reset_pulse();
    set_in(1'b1, 1'b0, 1'b0);
    cycle();
    for (int i = 0; i < 2; i++) begin
      set_in(1'b1, 1'b0, 1'b1);
      cycle();
    end
    reset_pulse();
    set_in(1'b1, 1'b1, 1'b0);
    cycle();
    chk("t6_tie_m0", m0_gnt, 1'b1);

    // Random traffic with sticky requests and occasional resets
    r0 = 1'b0;
    r1 = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) r0 = ~r0;
      if ($urandom_range(0, 4) == 0) r1 = ~r1;
      if ($urandom_range(0, 299) == 0) reset_pulse();
      set_in(r0, r1, 1'($urandom_range(0, 1)));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
